// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared types and saturation bounds for the weight-stationary PE
package pe_pkg;

    typedef enum logic {
        MODE_WS = 1'b0,
        MODE_OS = 1'b1
    } pe_mode_e;

    // Wide enough to hold any psum + product sum without loss before range checks.
    localparam int SAT_XW = 128;

    function automatic logic signed [SAT_XW-1:0] sat_max(input int w, input bit sgn);
        logic signed [SAT_XW-1:0] one;
        one = SAT_XW'(1);
        return sgn ? (one <<< (w - 1)) - one : (one <<< w) - one;
    endfunction

    function automatic logic signed [SAT_XW-1:0] sat_min(input int w, input bit sgn);
        logic signed [SAT_XW-1:0] one;
        one = SAT_XW'(1);
        return sgn ? -(one <<< (w - 1)) : '0;
    endfunction

endpackage

// File: rtl/processing_element_ws_dbuf_lane.sv
// rtl/processing_element_ws_dbuf_lane.sv - one MAC lane: zero gate, mult pipe, add/acc with saturation
module pe_mac_lane
    import pe_pkg::*;
#(
    parameter int WIDTH_A     = 16,
    parameter int WIDTH_B     = 16,
    parameter int WIDTH_MAC   = 48,
    parameter int STAGE       = 1,
    parameter int SIGNED      = 0,
    parameter int SATURATE    = 0,
    parameter int ZERO_GATING = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [WIDTH_A-1:0]   act,
    input  logic [WIDTH_B-1:0]   wei,
    input  logic [WIDTH_MAC-1:0] psum_in,
    input  logic                 ws_fire,
    input  logic                 os_tok,
    input  logic                 dump_go,
    output logic [WIDTH_MAC-1:0] psum_out,
    output logic                 ovf
);
    localparam int PW = 2 * ((WIDTH_A > WIDTH_B) ? WIDTH_A : WIDTH_B);
    localparam logic signed [SAT_XW-1:0] SMAX = sat_max(WIDTH_MAC, SIGNED != 0);
    localparam logic signed [SAT_XW-1:0] SMIN = sat_min(WIDTH_MAC, SIGNED != 0);

    function automatic logic [PW-1:0] mul(input logic [WIDTH_A-1:0] a, input logic [WIDTH_B-1:0] b);
        logic [PW-1:0] ax, bx;
        if (SIGNED != 0) begin
            ax = PW'($signed(a));
            bx = PW'($signed(b));
        end else begin
            ax = PW'(a);
            bx = PW'(b);
        end
        return ax * bx;
    endfunction

    logic                 gate_in;
    logic [PW-1:0]        prod_d;
    logic [WIDTH_MAC-1:0] psum_d;
    logic [WIDTH_MAC-1:0] acc, base, res;
    logic [PW-1:0]        addend;
    logic signed [SAT_XW-1:0] base_x, prod_x, sum_x;
    logic                 oor;

    assign gate_in = (ZERO_GATING != 0) && ((act == '0) || (wei == '0));

    generate
        if (STAGE == 0) begin : g_comb
            assign prod_d = (gate_in || !in_valid) ? '0 : mul(act, wei);
            assign psum_d = psum_in;
        end else begin : g_pipe
            logic [WIDTH_A-1:0]   a_q;
            logic [WIDTH_B-1:0]   w_q;
            logic                 zero_q;
            logic [WIDTH_MAC-1:0] ps_q [STAGE];
            logic [PW-1:0]        prod_s1;

            // Operand regs hold on gated tokens so the multiplier inputs do not toggle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0; w_q <= '0; zero_q <= 1'b0;
                    for (int i = 0; i < STAGE; i++) ps_q[i] <= '0;
                end else if (clear) begin
                    a_q <= '0; w_q <= '0; zero_q <= 1'b0;
                    for (int i = 0; i < STAGE; i++) ps_q[i] <= '0;
                end else begin
                    if (in_valid && !gate_in) begin
                        a_q <= act;
                        w_q <= wei;
                    end
                    zero_q   <= gate_in;
                    ps_q[0]  <= psum_in;
                    for (int i = 1; i < STAGE; i++) ps_q[i] <= ps_q[i-1];
                end
            end

            assign prod_s1 = zero_q ? '0 : mul(a_q, w_q);
            assign psum_d  = ps_q[STAGE-1];

            if (STAGE > 1) begin : g_deep
                logic [PW-1:0] pr_q [STAGE-1];
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        for (int i = 0; i < STAGE - 1; i++) pr_q[i] <= '0;
                    end else if (clear) begin
                        for (int i = 0; i < STAGE - 1; i++) pr_q[i] <= '0;
                    end else begin
                        pr_q[0] <= prod_s1;
                        for (int i = 1; i < STAGE - 1; i++) pr_q[i] <= pr_q[i-1];
                    end
                end
                assign prod_d = pr_q[STAGE-2];
            end else begin : g_shallow
                assign prod_d = prod_s1;
            end
        end
    endgenerate

    // One shared adder: WS adds to the northern psum, OS and dump add to the accumulator.
    always_comb begin
        base   = ws_fire ? psum_d : acc;
        addend = (ws_fire || os_tok) ? prod_d : '0;
        if (SIGNED != 0) begin
            base_x = SAT_XW'($signed(base));
            prod_x = SAT_XW'($signed(addend));
        end else begin
            base_x = SAT_XW'(base);
            prod_x = SAT_XW'(addend);
        end
        sum_x = base_x + prod_x;
        res   = sum_x[WIDTH_MAC-1:0];
        oor   = 1'b0;
        if (sum_x > SMAX) begin
            oor = 1'b1;
            if (SATURATE != 0) res = SMAX[WIDTH_MAC-1:0];
        end else if (sum_x < SMIN) begin
            oor = 1'b1;
            if (SATURATE != 0) res = SMIN[WIDTH_MAC-1:0];
        end
    end

    assign ovf = oor && (ws_fire || os_tok || dump_go);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psum_out <= '0;
            acc      <= '0;
        end else if (clear) begin
            psum_out <= '0;
            acc      <= '0;
        end else if (ws_fire) begin
            psum_out <= res;
        end else if (dump_go) begin
            psum_out <= res;
            acc      <= '0;
        end else if (os_tok) begin
            acc <= res;
        end
    end

endmodule

// File: rtl/processing_element_ws_dbuf.sv
// rtl/processing_element_ws_dbuf.sv - multi-lane weight-stationary PE with double-buffered weights
module processing_element_ws_dbuf
    import pe_pkg::*;
#(
    parameter int WIDTH_A     = 16,
    parameter int WIDTH_B     = 16,
    parameter int WIDTH_MAC   = 48,
    parameter int LANES       = 2,
    parameter int STAGE       = 1,
    parameter int SIGNED      = 0,
    parameter int SATURATE    = 0,
    parameter int ZERO_GATING = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         mode_os,
    input  logic [LANES*WIDTH_A-1:0]     act_in,
    input  logic                         act_valid_in,
    output logic [LANES*WIDTH_A-1:0]     act_out,
    output logic                         act_valid_out,
    input  logic [LANES*WIDTH_B-1:0]     wei_in,
    input  logic                         wei_valid_in,
    output logic [LANES*WIDTH_B-1:0]     wei_out,
    output logic                         wei_valid_out,
    input  logic                         swap_in,
    output logic                         swap_out,
    input  logic [LANES*WIDTH_MAC-1:0]   psum_in,
    input  logic                         dump_in,
    output logic [LANES*WIDTH_MAC-1:0]   psum_out,
    output logic                         psum_valid,
    output logic                         sat_flag
);
    logic [LANES*WIDTH_B-1:0] shadow, active;
    logic                     shadow_full, dump_def;
    logic                     tok_v;
    pe_mode_e                 tok_mode;
    logic                     ws_fire, os_tok, dump_req, dump_go;
    logic [LANES-1:0]         lane_ovf;

    generate
        if (STAGE == 0) begin : g_nopipe
            assign tok_v    = act_valid_in;
            assign tok_mode = pe_mode_e'(mode_os);
        end else begin : g_pipe
            logic [STAGE-1:0] v_q, m_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q <= '0;
                    m_q <= '0;
                end else if (clear) begin
                    v_q <= '0;
                    m_q <= '0;
                end else begin
                    v_q[0] <= act_valid_in;
                    m_q[0] <= mode_os;
                    for (int i = 1; i < STAGE; i++) begin
                        v_q[i] <= v_q[i-1];
                        m_q[i] <= m_q[i-1];
                    end
                end
            end
            assign tok_v    = v_q[STAGE-1];
            assign tok_mode = pe_mode_e'(m_q[STAGE-1]);
        end
    endgenerate

    // A WS result owns psum_out this cycle; a coincident dump waits one cycle.
    assign ws_fire  = tok_v && (tok_mode == MODE_WS);
    assign os_tok   = tok_v && (tok_mode == MODE_OS);
    assign dump_req = dump_in || dump_def;
    assign dump_go  = dump_req && !ws_fire;

    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            pe_mac_lane #(
                .WIDTH_A(WIDTH_A), .WIDTH_B(WIDTH_B), .WIDTH_MAC(WIDTH_MAC), .STAGE(STAGE),
                .SIGNED(SIGNED), .SATURATE(SATURATE), .ZERO_GATING(ZERO_GATING)
            ) u_lane (
                .clk     (clk),
                .rst     (rst),
                .clear   (clear),
                .in_valid(act_valid_in),
                .act     (act_in[l*WIDTH_A +: WIDTH_A]),
                .wei     (active[l*WIDTH_B +: WIDTH_B]),
                .psum_in (psum_in[l*WIDTH_MAC +: WIDTH_MAC]),
                .ws_fire (ws_fire),
                .os_tok  (os_tok),
                .dump_go (dump_go),
                .psum_out(psum_out[l*WIDTH_MAC +: WIDTH_MAC]),
                .ovf     (lane_ovf[l])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_out <= '0; act_valid_out <= 1'b0; wei_out <= '0; wei_valid_out <= 1'b0;
            swap_out <= 1'b0; shadow <= '0; shadow_full <= 1'b0; active <= '0;
            dump_def <= 1'b0; psum_valid <= 1'b0; sat_flag <= 1'b0;
        end else if (clear) begin
            act_out <= '0; act_valid_out <= 1'b0; wei_out <= '0; wei_valid_out <= 1'b0;
            swap_out <= 1'b0; shadow <= '0; shadow_full <= 1'b0; active <= '0;
            dump_def <= 1'b0; psum_valid <= 1'b0; sat_flag <= 1'b0;
        end else begin
            act_out       <= act_in;
            act_valid_out <= act_valid_in;
            wei_out       <= wei_in;
            swap_out      <= swap_in;
            // First valid word into an empty shadow is consumed; anything else rides the chain.
            if (wei_valid_in && !shadow_full) begin
                shadow        <= wei_in;
                shadow_full   <= 1'b1;
                wei_valid_out <= 1'b0;
            end else begin
                wei_valid_out <= wei_valid_in;
            end
            if (swap_in && shadow_full) begin
                active      <= shadow;
                shadow_full <= 1'b0;
            end
            dump_def   <= dump_req && ws_fire;
            psum_valid <= ws_fire || dump_go;
            sat_flag   <= sat_flag || (|lane_ovf);
        end
    end

endmodule
